fifo_out_stage: RTL
===================

Name: fifo_out_stage

Overview:
- Read-side drain stage that sits directly downstream of the FIFO controller and its dual-port RAM.
- Issues single-cycle read pulses to the controller whenever the FIFO is non-empty and local buffer space is available.
- Tracks the RAM read latency and captures returning words into a small output buffer.
- Presents captured words to the consumer on a valid/ready handshake, with sustained throughput of one word per cycle.

Parameters:
- WIDTH, 8: data word width in bits.
- RD_LAT, 2: cycles from fifo_rd asserted to the word on ram_rdata (address registered in controller + synchronous RAM read); legal range 1-3.
- BUF_ENTRIES, 4: output buffer depth; must be ≥ RD_LAT+1 and a power of two.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  empty flag from the FIFO controller.
- fifo_rd  out  1  read pulse to the FIFO controller; one word popped per high cycle.
- ram_rdata  in  WIDTH  RAM read data; valid exactly RD_LAT cycles after the corresponding fifo_rd.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  head word of the output buffer.
- busy  out  1  high while any read is in flight or the buffer is non-empty.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: fifo_rd=0, out_valid=0, out_data=0, busy=0. Also cleared on reset: latency shift register, buffer pointers, occupancy count, in-flight count.
- Read issue (combinational, from registered state): fifo_rd = ~fifo_empty & ~reset & (inflight + occupancy < BUF_ENTRIES).
  - This credit check guarantees every returning word has a slot. No word is ever dropped, and no backpressure is applied to the RAM.
- Latency tracking: a RD_LAT-bit shift register records fifo_rd each cycle; when its last stage is 1, ram_rdata is written to the buffer at wr_ptr that clock edge.
  - inflight = popcount of the shift register, width clog2(RD_LAT+1).
- Buffer:
  - Circular, BUF_ENTRIES x WIDTH, with wr_ptr/rd_ptr of clog2(BUF_ENTRIES) bits that wrap naturally.
  - Occupancy counter is clog2(BUF_ENTRIES)+1 bits.
- Output:
  - out_valid = (occupancy != 0); out_data = buf[rd_ptr].
  - A pop occurs on out_valid & out_ready; rd_ptr advances at that edge.
  - out_data must be held stable while out_valid=1 and out_ready=0.
- Simultaneous capture and pop: occupancy unchanged; both pointers advance.
- Capture into an empty buffer: out_valid rises the cycle after capture, so minimum latency fifo_rd → out_valid is RD_LAT+1 cycles.
- Throughput: with out_ready held high and the FIFO non-empty, fifo_rd stays high every cycle and out_valid stays high every cycle after the fill latency.
- FIFO going empty: fifo_rd drops the same cycle fifo_empty is seen high. Words already in flight still land; busy stays high until they are consumed.
- Full stall: with out_ready=0, reads stop once inflight+occupancy = BUF_ENTRIES. Resumption needs a pop, not an empty FIFO.
- Reset mid-operation: in-flight words are discarded and the buffer is emptied. The upstream FIFO contents are the controller's responsibility (its own reset).
- Illegal parameters (RD_LAT outside 1-3, BUF_ENTRIES < RD_LAT+1) are flagged by an elaboration-time check that fails the build.

Optional Feature:
- Macro FIFO_OUT_STATS_EN.
- When defined, adds two output ports:
  - words_out [15:0]: increments on every pop.
  - stall_cycles [15:0]: increments each cycle with out_valid=1 and out_ready=0.
- Both counters saturate at 16'hFFFF and clear on reset.
- When not defined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset with fifo_empty=0 → fifo_rd=0, out_valid=0, busy=0 during reset; fifo_rd=1 on the first cycle after reset deasserts.
- Preload 10 words 0x01..0x0A, out_ready=1, RD_LAT=2 → fifo_rd high 10 consecutive cycles; out_valid first high 3 cycles after the first fifo_rd; out_data = 0x01..0x0A on consecutive cycles with no gaps.
- 10 words queued, out_ready=0 → exactly 4 fifo_rd pulses, out_data held at 0x01. Raise out_ready → remaining 6 words follow in order with no loss or duplicate.
- One word in the FIFO, fifo_empty rises after the pop → a single fifo_rd pulse; busy high until 0x01 is popped, then busy=0.
- Assert reset with 2 in flight and 2 buffered → next cycle out_valid=0, occupancy=0; the stale RAM returns after reset are not captured.
- out_ready toggled 1/0 every cycle over 20 words → data in order, no loss. With FIFO_OUT_STATS_EN defined: words_out=20; stall_cycles equals the count of cycles with out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/fifo_out_stage.sv
// fifo_out_stage: read-side drain stage between FIFO controller/RAM and a valid/ready consumer.
// Optional statistics counters (words_out, stall_cycles) are enabled by defining FIFO_OUT_STATS_EN.
module fifo_out_stage #(
    parameter int WIDTH = 8,
    parameter int RD_LAT = 2,
    parameter int BUF_ENTRIES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
`ifdef FIFO_OUT_STATS_EN
    ,
    output logic [15:0]      words_out,
    output logic [15:0]      stall_cycles
`endif
);
    localparam int PW = $clog2(BUF_ENTRIES);
    localparam int IW = $clog2(RD_LAT + 1);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    if (RD_LAT < 1 || RD_LAT > 3 || BUF_ENTRIES < RD_LAT + 1 || (BUF_ENTRIES & (BUF_ENTRIES - 1)) != 0) begin : g_bad_params
        $error("fifo_out_stage: RD_LAT must be 1-3 and BUF_ENTRIES a power of two >= RD_LAT+1");
    end

    logic [RD_LAT-1:0] lat;
    logic [IW-1:0]     inflight;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     occ;
    logic [WIDTH-1:0]  mem [BUF_ENTRIES];
    logic              capture;
    logic              pop;

    // Count reads still travelling through the RAM pipeline.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + IW'(lat[i]);
    end

    // Issue a read only when every outstanding word is guaranteed a buffer slot.
    always_comb begin
        fifo_rd   = ~fifo_empty & ~reset & ((SW'(inflight) + SW'(occ)) < SW'(BUF_ENTRIES));
        capture   = lat[RD_LAT-1];
        out_valid = occ != '0;
        pop       = out_valid & out_ready;
        out_data  = out_valid ? mem[rd_ptr] : '0;
        busy      = out_valid | (lat != '0);
    end

    // Latency shift register: the last stage marks the cycle ram_rdata is valid.
    always_ff @(posedge clk) begin
        if (reset) lat <= '0;
        else       lat <= RD_LAT'({lat, fifo_rd});
    end

    // Pointers and occupancy; a simultaneous capture and pop leaves occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(capture);
            rd_ptr <= rd_ptr + PW'(pop);
            occ    <= occ + CW'(capture) - CW'(pop);
        end
    end

    // Buffer storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= ram_rdata;
    end

`ifdef FIFO_OUT_STATS_EN
    // Saturating counters of delivered words and consumer stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            words_out    <= '0;
            stall_cycles <= '0;
        end else begin
            if (pop && words_out != 16'hFFFF) words_out <= words_out + 16'd1;
            if (out_valid && !out_ready && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif
endmodule
